// File: rtl/alu_seq.sv
// Registered ALU execution unit with a start/done handshake.
// Single-cycle logic/arith/branch codes; shifts iterate one bit per cycle.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       gin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zout,
    output logic             branch,
    output logic             vflag
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_BEN = 4'b1000;
    localparam logic [3:0] OP_BVF = 4'b1001;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic             left, left_n;
    logic [WIDTH-1:0] result_n;
    logic             zout_n, branch_n, vflag_n, done_n;
    logic             upd;

    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf, slt;

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign slt     = $signed(a) < $signed(b);
    assign busy    = (state == SHIFT);

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        left_n   = left;
        result_n = result;
        branch_n = branch;
        vflag_n  = vflag;
        done_n   = 1'b0;
        upd      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    upd      = 1'b1;
                    done_n   = 1'b1;
                    branch_n = 1'b0;
                    result_n = '0;
                    case (gin)
                        OP_AND: result_n = a & b;
                        OP_OR:  result_n = a | b;
                        OP_ADD: begin
                            result_n = sum;
                            vflag_n  = add_ovf;
                        end
                        OP_SUB: begin
                            result_n = diff;
                            vflag_n  = sub_ovf;
                        end
                        OP_SLT: result_n = {{(WIDTH-1){1'b0}}, slt};
                        OP_BEN: begin
                            result_n = diff;
                            branch_n = (a != b);
                        end
                        OP_BVF: branch_n = vflag;
                        OP_SLL, OP_SRL: begin
                            // Shifts defer the result update to the SHIFT exit
                            upd      = 1'b0;
                            done_n   = 1'b0;
                            branch_n = branch;
                            result_n = result;
                            state_n  = SHIFT;
                            shreg_n  = a;
                            cnt_n    = b[SHW-1:0];
                            left_n   = (gin == OP_SLL);
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    shreg_n = left ? (shreg << 1) : (shreg >> 1);
                    cnt_n   = cnt - 1'b1;
                end else begin
                    result_n = shreg;
                    branch_n = 1'b0;
                    upd      = 1'b1;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        zout_n = upd ? (result_n == '0) : zout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            left   <= 1'b0;
            result <= '0;
            zout   <= 1'b0;
            branch <= 1'b0;
            vflag  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            left   <= left_n;
            result <= result_n;
            zout   <= zout_n;
            branch <= branch_n;
            vflag  <= vflag_n;
            done   <= done_n;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table plus shift/reset sequences,
// expected results queued at issue and checked on each done.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  gin;
    logic [31:0] a, b;
    logic        busy, done, zout, branch, vflag;
    logic [31:0] result;

    alu_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .gin(gin),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zout(zout), .branch(branch), .vflag(vflag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        br;
        logic        v;
    } exp_t;

    typedef struct {
        logic [3:0]  gin;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    vec_t tbl[15];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("zout", {31'd0, zout}, {31'd0, e.z});
                chk("branch", {31'd0, branch}, {31'd0, e.br});
                chk("vflag", {31'd0, vflag}, {31'd0, e.v});
            end
        end
    end

    task automatic issue(input logic [3:0] g, input logic [31:0] xa,
                         input logic [31:0] xb, input exp_t e);
        start = 1'b1;
        gin   = g;
        a     = xa;
        b     = xb;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic shift_op(input logic [3:0] g, input logic [31:0] xa,
                            input logic [4:0] sh, input logic [31:0] er,
                            input logic ev, input bit ign, input bit follow);
        int lat = 0;
        int bc  = 0;
        start = 1'b1;
        gin   = g;
        a     = xa;
        b     = {27'd0, sh};
        q.push_back('{er, er == 32'd0, 1'b0, ev});
        @(posedge clk);
        #1;
        for (int k = 1; k <= 60; k++) begin
            start = ign && k >= 2 && k <= int'(sh);
            gin   = 4'b0010;
            a     = 32'h7FFFFFFF;
            b     = 32'd1;
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("shift_latency", lat, int'(sh) + 2);
        chk("shift_busy_cycles", bc, int'(sh) + 1);
        if (follow) begin
            start = 1'b1;
            gin   = 4'b0010;
            a     = 32'd2;
            b     = 32'd3;
            q.push_back('{32'd5, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h1, '{32'h80000000, 1'b0, 1'b0, 1'b1}};
        tbl[1]  = '{4'b1001, 32'h0, 32'h0, '{32'h0, 1'b1, 1'b1, 1'b1}};
        tbl[2]  = '{4'b0110, 32'h5, 32'h5, '{32'h0, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{4'b1000, 32'h3, 32'h4, '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b0}};
        tbl[4]  = '{4'b1000, 32'h4, 32'h4, '{32'h0, 1'b1, 1'b0, 1'b0}};
        tbl[5]  = '{4'b0111, 32'hFFFFFFFF, 32'h1, '{32'h1, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{4'b0000, 32'hF0F0, 32'h0FF0, '{32'h00F0, 1'b0, 1'b0, 1'b0}};
        tbl[7]  = '{4'b0001, 32'hF0F0, 32'h0FF0, '{32'hFFF0, 1'b0, 1'b0, 1'b0}};
        tbl[8]  = '{4'b1001, 32'h1, 32'h1, '{32'h0, 1'b1, 1'b0, 1'b0}};
        tbl[9]  = '{4'b0110, 32'h80000000, 32'h1, '{32'h7FFFFFFF, 1'b0, 1'b0, 1'b1}};
        tbl[10] = '{4'b1100, 32'h5, 32'h6, '{32'h0, 1'b1, 1'b0, 1'b1}};
        tbl[11] = '{4'b0010, 32'h2, 32'h3, '{32'h5, 1'b0, 1'b0, 1'b0}};
        tbl[12] = '{4'b0111, 32'h1, 32'hFFFFFFFF, '{32'h0, 1'b1, 1'b0, 1'b0}};
        tbl[13] = '{4'b0100, 32'h9, 32'h9, '{32'h0, 1'b1, 1'b0, 1'b0}};
        tbl[14] = '{4'b0010, 32'hFFFFFFFF, 32'h1, '{32'h0, 1'b1, 1'b0, 1'b0}};

        reset = 1'b1;
        start = 1'b0;
        gin   = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        idle_cycles(3);
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, zout, branch, vflag}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // back-to-back single-cycle operations
        for (int i = 0; i < 15; i++)
            issue(tbl[i].gin, tbl[i].a, tbl[i].b, tbl[i].e);
        start = 1'b0;
        idle_cycles(2);
        chk("busy_single", {31'd0, busy}, 32'd0);

        shift_op(4'b0011, 32'h1, 5'd31, 32'h80000000, 1'b0, 1'b1, 1'b0);
        shift_op(4'b0101, 32'h80000000, 5'd0, 32'h80000000, 1'b0, 1'b0, 1'b0);
        shift_op(4'b0101, 32'hF0000000, 5'd4, 32'h0F000000, 1'b0, 1'b1, 1'b1);
        idle_cycles(2);
        shift_op(4'b0011, 32'h3, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0);
        shift_op(4'b0011, 32'h1, 5'd1, 32'h2, 1'b0, 1'b0, 1'b0);

        // reset aborts a shift and clears the sticky flag
        issue(4'b0010, 32'h7FFFFFFF, 32'h1, '{32'h80000000, 1'b0, 1'b0, 1'b1});
        start = 1'b1;
        gin   = 4'b0011;
        a     = 32'h1;
        b     = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle_cycles(3);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        idle_cycles(15);
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_flags", {29'd0, zout, branch, vflag}, 32'd0);
        @(posedge clk);
        #1;
        issue(4'b0010, 32'h7FFFFFFF, 32'h1, '{32'h80000000, 1'b0, 1'b0, 1'b1});
        start = 1'b0;
        idle_cycles(2);

        // reset dominates a simultaneous start
        reset = 1'b1;
        start = 1'b1;
        gin   = 4'b0001;
        a     = 32'h5;
        b     = 32'h0;
        idle_cycles(1);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_dom_done", {31'd0, done}, 32'd0);
        chk("rst_dom_vflag", {31'd0, vflag}, 32'd0);
        chk("rst_dom_result", result, 32'd0);
        @(posedge clk);
        #1;
        issue(4'b1100, 32'h1, 32'h2, '{32'h0, 1'b1, 1'b0, 1'b0});
        start = 1'b0;

        for (int i = 0; i < 20 && q.size() != 0; i++)
            @(posedge clk);
        idle_cycles(2);
        chk("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, and returns the result through a start/done handshake.
- Logic, arithmetic, compare and branch codes complete in one cycle.
- Shift codes iterate one bit per cycle.
- Keeps a sticky overflow flag for the bvf branch.
- Sits in the execute stage between the register file/immediate mux and the writeback/PC-select logic.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHW, 5, shift-amount width in bits; equals log2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; gin/a/b are sampled on the same edge.
- gin  input  4  ALU control code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
- busy  output  1  high while a shift is in progress; start is ignored while high.
- done  output  1  one-cycle pulse; result, zout and branch are valid in this cycle.
- result  output  WIDTH  registered result; holds its value until the next done.
- zout  output  1  registered (result == 0), updated together with result.
- branch  output  1  registered branch-taken indication, updated together with result.
- vflag  output  1  sticky signed-overflow flag.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset:
  - state returns to IDLE.
  - busy, done, result, zout, branch and vflag all go to 0.
  - Reset dominates a simultaneous start.
  - Reset during a shift aborts it; no done is produced.
- States: IDLE and SHIFT. busy = (state == SHIFT).
- Start acceptance:
  - start is sampled only in IDLE.
  - In SHIFT, start is ignored and no queueing occurs.
  - start is also accepted in the done cycle of a shift, because state is IDLE again.
- Single-cycle codes: if start is high in cycle N, then result/zout/branch are updated and done is high in cycle N+1. busy stays 0. start may be asserted every cycle and gives one done per start.
- Code map (anything not listed is unused):
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, low WIDTH bits. vflag <= signed overflow of the add.
  - 0110 SUB: a - b. vflag <= signed overflow of the subtract.
  - 0111 SLT: result = 1 if a < b signed, else 0. vflag unchanged.
  - 0011 SLL: shift a left logical by b[SHW-1:0].
  - 0101 SRL: shift a right logical by b[SHW-1:0].
  - 1000 BEN: result = a - b; branch = (a != b). vflag unchanged.
  - 1001 BVF: result = 0; branch = vflag value held before this operation. vflag unchanged.
  - Unused codes (0100, 1010-1111): result = 0, branch = 0, done still pulses, vflag unchanged.
- branch is 0 for every code except BEN and BVF.
- vflag is written only by ADD and SUB. It holds its value otherwise, including across shifts and resets of other outputs, until reset.
- Shifts:
  - On start in IDLE: load shreg = a and cnt = b[SHW-1:0], then go to SHIFT.
  - In SHIFT with cnt != 0: shift shreg by 1 in the requested direction (zero fill) and decrement cnt.
  - In SHIFT with cnt == 0: result <= shreg, done <= 1, return to IDLE.
  - Timing: start in cycle N gives busy high in cycles N+1..N+sh+1 and done high in cycle N+sh+2.
  - Shift amount 0: result = a, done in cycle N+2.
  - Maximum amount 31: done in cycle N+33.
- Wrap-around: ADD/SUB results are truncated to WIDTH bits and carry-out is discarded. cnt never underflows.
- Between operations, done = 0 and result/zout/branch keep their values.

Test Plan:
- Reset, then start gin=0010, a=0x7FFFFFFF, b=1 -> next cycle done=1, result=0x80000000, zout=0, vflag=1. Then gin=1001 -> done, branch=1, result=0, zout=1.
- gin=0110, a=5, b=5 -> result=0, zout=1, vflag=0. Then gin=1000, a=3, b=4 -> result=0xFFFFFFFF, branch=1. Then gin=1000, a=4, b=4 -> branch=0.
- gin=0111, a=0xFFFFFFFF, b=1 -> result=1. Then gin=0000/0001 with a=0xF0F0, b=0x0FF0 -> results 0x00F0 and 0xFFF0. Back-to-back starts on consecutive cycles -> one done per start.
- gin=0011, a=1, b=31 -> busy high for 32 cycles, done in cycle N+33 with result=0x80000000. start pulses while busy are ignored (exactly one done). gin=0101, a=0x80000000, b=0 -> done at N+2, result=0x80000000.
- Start SLL with b=10, assert reset at cycle N+4 -> no done, all outputs 0, vflag=0; next start gin=0010 works normally.
- Start unused code 1100 -> done pulses, result=0, zout=1, branch=0, vflag unchanged.
